program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are named as in the codebase.
REQ-002 CLK  in  1  single system clock; all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 load_valid  in  1  host presents a program byte.
REQ-005 load_data  in  8  program byte (one instruction).
REQ-006 load_last  in  1  marks final byte of the program; sampled with load_valid.
REQ-007 load_ready  out  1  block accepts a byte this cycle.
REQ-008 start  in  1  request to enter RUN.
REQ-009 halt  in  1  request to leave RUN.
REQ-010 PC  in  8  fetch address from the CPU.
REQ-011 instruction  out  8  instruction served to the CPU.
REQ-012 cpu_run  out  1  high only in RUN; drives the CPU's active-low RESET.
REQ-013 loaded_count  out  9  number of valid bytes in memory (0..256).
REQ-014 overflow  out  1  sticky; program exceeded 256 bytes.
REQ-015 start_err  out  1  one-cycle pulse; start refused because memory is empty.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN; a beat is accepted when load_valid && load_ready.
REQ-017 load_ready SHALL be 1 in IDLE and LOAD and 0 in RUN; beats in RUN are ignored.
REQ-018 IDLE, accepted beat: write load_data to address 0, set loaded_count=1, clear overflow, go to LOAD; if load_last, go to IDLE instead.
REQ-019 LOAD, accepted beat: write to address loaded_count[7:0], increment loaded_count; if load_last, go to IDLE.
REQ-020 LOAD, accepted beat with loaded_count==255 and no load_last: write, set loaded_count=256 and overflow=1, go to IDLE; the remainder of the stream restarts at address 0.
REQ-021 IDLE, start with loaded_count>0: go to RUN next cycle; with loaded_count==0: stay in IDLE, pulse start_err for one cycle.
REQ-022 IDLE, accepted beat and start in the same cycle: the beat wins; start is dropped with no start_err.
REQ-023 RUN, halt: go to IDLE next cycle; start in RUN is ignored; halt outside RUN is ignored.
REQ-024 LOAD ignores start and halt; no timeout; load_valid may idle indefinitely.
REQ-025 Memory write SHALL be synchronous on the accepting edge; read SHALL be combinational (zero latency) so the single-cycle CPU fetches in the same cycle.
REQ-026 instruction = mem[PC] when state==RUN and PC < loaded_count; otherwise 8'h00.
REQ-027 cpu_run SHALL be registered from state (high the cycle after the RUN transition; low the cycle after halt).

Reset
REQ-028 Reset SHALL force state=IDLE, cpu_run=0, loaded_count=0, overflow=0, start_err=0; instruction reads 8'h00.
REQ-029 Memory contents are not cleared by reset; after reset they are unreachable until reloaded (loaded_count=0).
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately; a beat presented on the same edge is not written.

Structure
REQ-031 The shared package SHALL hold the state encoding, MEM_DEPTH=256, ADDR_W=8, and NOP_INSTR=8'h00.
REQ-032 The memory SHALL be one sub-module, instr_ram (256x8, sync write, async read); FSM, counter and flags remain in program_loader.

Verification
REQ-033 Load 3 bytes 0x4D,0x12,0xC3 (last on 3rd), start -> loaded_count=3, cpu_run=1 one cycle later, PC=1 gives 0x12, PC=3 gives 0x00.
REQ-034 Start after reset with nothing loaded -> start_err pulses once, cpu_run stays 0, state IDLE.
REQ-035 Stream 257 bytes with no load_last -> overflow=1, loaded_count=256 after 256th beat; 257th byte writes address 0 and loaded_count=1.
REQ-036 In RUN, load_valid=1 with data 0xFF -> load_ready=0, memory unchanged; halt -> cpu_run=0 next cycle, instruction=0x00.
REQ-037 Drop RESET low during beat 2 of a 4-byte load -> loaded_count=0 immediately, beat not written, reload from address 0 succeeds.
REQ-038 Same-cycle load_valid and start in IDLE with loaded_count=2 -> byte written to address 0, loaded_count=1, state LOAD, no RUN entry.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, memory geometry
// and the instruction served when nothing valid is addressed.
package program_loader_pkg;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  // One extra bit so the count can represent a completely full memory (256).
  localparam int unsigned COUNT_W   = ADDR_W + 1;

  localparam logic [DATA_W-1:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10
  } state_e;

endpackage : program_loader_pkg

// File: rtl/instr_ram.sv
// Instruction memory, MEM_DEPTH x DATA_W.
// Synchronous write, combinational read so a single-cycle CPU fetches with zero latency.
// Contents are deliberately not reset.
// Ports:
//   clk_i  - clock
//   we     - write enable (sampled on rising edge)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module instr_ram
  import program_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : instr_ram

// File: rtl/program_loader.sv
// Program loader: accepts a byte stream from a host into instruction memory, then
// holds a single-cycle CPU in reset until started and serves it instructions.
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   load_valid/data/last, load_ready - host byte stream handshake
//   start, halt      - enter / leave RUN
//   pc               - CPU fetch address
//   instruction      - fetched instruction (NOP outside the loaded program or outside RUN)
//   cpu_run          - registered RUN indication, drives the CPU's active-low reset
//   loaded_count     - number of valid bytes held (0..256)
//   overflow         - sticky, a stream exceeded the memory size
//   start_err        - one-cycle pulse, start refused because memory is empty
module program_loader
  import program_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_valid,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  instruction,
  output logic               cpu_run,
  output logic [COUNT_W-1:0] loaded_count,
  output logic               overflow,
  output logic               start_err
);

  localparam logic [COUNT_W-1:0] LastSlot = COUNT_W'(MEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                start_err_q, start_err_d;
  logic                cpu_run_q;

  logic                accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_rdata;

  assign load_ready = (state_q != StRun);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    start_err_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;

    unique case (state_q)
      StIdle: begin
        // An accepted beat takes priority over start; start is silently dropped.
        if (accept) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          count_d    = COUNT_W'(1);
          overflow_d = 1'b0;
          state_d    = load_last ? StIdle : StLoad;
        end else if (start) begin
          if (count_q != '0) begin
            state_d = StRun;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_waddr = count_q[ADDR_W-1:0];
          count_d   = count_q + COUNT_W'(1);
          if (load_last) begin
            state_d = StIdle;
          end else if (count_q == LastSlot) begin
            // Memory full and the stream keeps going: the rest restarts at address 0.
            overflow_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StRun: begin
        if (halt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      start_err_q <= 1'b0;
      cpu_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      start_err_q <= start_err_d;
      cpu_run_q   <= (state_q == StRun);
    end
  end

  // Gate with reset so a beat presented on the edge that reset aborts is not written.
  instr_ram u_instr_ram (
    .clk_i (clk_i),
    .we    (mem_we && rst_ni),
    .waddr (mem_waddr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  assign instruction  = ((state_q == StRun) && ({1'b0, pc} < count_q)) ? mem_rdata : NOP_INSTR;
  assign cpu_run      = cpu_run_q;
  assign loaded_count = count_q;
  assign overflow     = overflow_q;
  assign start_err    = start_err_q;

endmodule : program_loader
